// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_ctrl_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Instructions are word aligned, so the low two address bits are always dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus: redirect input, instruction memory port and decode output.
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    // Handshakes: a request completes in any cycle with imem_req && imem_ack and its
    // address is held until then; an instruction transfers to decode in any cycle
    // with inst_valid && !stall, otherwise inst/inst_pc are held.
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            inst_valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;

    modport master (
        input  stall, redirect_valid, redirect_pc, imem_ack, imem_rdata,
        output imem_req, imem_addr, inst_valid, inst, inst_pc
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_ack, imem_rdata,
        input  imem_req, imem_addr, inst_valid, inst, inst_pc
    );

endinterface

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding an instruction that arrived while decode was stalled.
module fetch_skid
    import fetch_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] data_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] data_o,
    output logic [XLEN-1:0] pc_o,
    output logic            valid_o
);

    logic [XLEN-1:0] data_q;
    logic [XLEN-1:0] pc_q;
    logic            valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            pc_q    <= pc_i;
            valid_q <= 1'b1;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request, one-instruction
// decode buffer backed by a skid entry, and redirect flush handling.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_ctrl_if.master        bus,
    output state_e              state_o
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            inst_valid_q, inst_valid_d;

    logic            skid_load, skid_clear, skid_valid;
    logic [XLEN-1:0] skid_data, skid_pc;

    logic            buf_free;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] target_pc;

    assign buf_free  = !inst_valid_q || !bus.stall;
    assign pc_inc    = pc_q + PC_STEP;
    assign target_pc = align_pc(bus.redirect_pc);

    fetch_skid u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (bus.imem_rdata),
        .pc_i    (req_addr_q),
        .data_o  (skid_data),
        .pc_o    (skid_pc),
        .valid_o (skid_valid)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;

        case (state_q)
            IDLE: begin
                state_d    = FETCH;
                pc_d       = bus.redirect_valid ? target_pc : pc_q;
                req_addr_d = pc_d;
            end
            FETCH: begin
                if (bus.redirect_valid) begin
                    pc_d         = target_pc;
                    inst_valid_d = 1'b0;
                    // Without an ack the old request must still be seen through.
                    if (bus.imem_ack) req_addr_d = target_pc;
                    else              state_d    = DRAIN;
                end else if (bus.imem_ack) begin
                    pc_d       = pc_inc;
                    req_addr_d = pc_inc;
                    if (buf_free) begin
                        inst_d       = bus.imem_rdata;
                        inst_pc_d    = req_addr_q;
                        inst_valid_d = 1'b1;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end
                end else if (inst_valid_q && !bus.stall) begin
                    inst_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (bus.redirect_valid) begin
                    skid_clear   = 1'b1;
                    inst_valid_d = 1'b0;
                    pc_d         = target_pc;
                    req_addr_d   = target_pc;
                    state_d      = FETCH;
                end else if (buf_free && skid_valid) begin
                    inst_d       = skid_data;
                    inst_pc_d    = skid_pc;
                    inst_valid_d = 1'b1;
                    skid_clear   = 1'b1;
                    req_addr_d   = pc_q;
                    state_d      = FETCH;
                end
            end
            DRAIN: begin
                if (bus.redirect_valid) begin
                    pc_d         = target_pc;
                    inst_valid_d = 1'b0;
                end
                if (bus.imem_ack) begin
                    req_addr_d = pc_d;
                    state_d    = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= align_pc(RESET_PC);
            req_addr_q   <= align_pc(RESET_PC);
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign bus.imem_req   = (state_q == FETCH) || (state_q == DRAIN);
    assign bus.imem_addr  = req_addr_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign state_o        = state_q;

endmodule
